// File: rtl/blk_65d721_pkg.sv
// Shared types and JTAG shadow-register field positions for the debug memory engine.
package demo_qsys_system_nios2_gen2_0_cpu_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam int JDO_CLR_ERR   = 35;
  localparam int JDO_READ      = 34;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/blk_65d721_timeout.sv
// Wait counter for outstanding memory requests; expired is high in the last
// allowed request cycle (count = TIMEOUT-1) so the caller can abort on that edge.
module demo_qsys_system_nios2_gen2_0_cpu_debug_mem_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic stop,
  output logic expired
);

  logic [15:0] r_cnt;
  logic        r_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (stop) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (r_run) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign expired = r_run && (r_cnt == 16'(TIMEOUT - 1));

endmodule

// File: rtl/blk_65d721.sv
// Debug memory access engine: turns decoded ocimem strobes plus the jdo shadow
// into single-word debug RAM reads/writes and reports results to the JTAG side.
module blk_65d721
  import demo_qsys_system_nios2_gen2_0_cpu_debug_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_req, r_we, r_ready, r_err;
  logic [31:0]       r_wdata, r_mon_d;

  logic w_idle, w_strobe, w_rd, w_wr, w_clr, w_start, w_stop, w_expired, w_unused;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // Priority a > no_action_a > b; lower strobes in the same cycle are dropped.
  assign w_rd     = w_idle & (take_action_ocimem_a | take_no_action_ocimem_a) & jdo[JDO_READ];
  assign w_wr     = w_idle & ~take_action_ocimem_a & ~take_no_action_ocimem_a & take_action_ocimem_b;
  assign w_clr    = w_idle & (take_action_ocimem_a | take_no_action_ocimem_a) & jdo[JDO_CLR_ERR];
  assign w_start  = w_rd | w_wr;
  assign w_stop   = ~w_idle & (mem_ack | w_expired);
  assign w_unused = ^{jdo[37:36], jdo[2:0]};

  demo_qsys_system_nios2_gen2_0_cpu_debug_mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_start),
    .stop    (w_stop),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_mon_d <= '0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (take_action_ocimem_a) r_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
          if (w_rd) begin
            r_state <= ST_READ;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_ready <= 1'b0;
          end else if (w_wr) begin
            r_state <= ST_WRITE;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_wdata <= jdo[JDO_WDATA_LSB +: 32];
            r_ready <= 1'b0;
          end
        end
        ST_READ, ST_WRITE: begin
          // An ack on the expiry cycle still counts as success.
          if (mem_ack) begin
            if (r_state == ST_READ) r_mon_d <= mem_rdata;
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_ready <= 1'b1;
          end else if (w_expired) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (~w_idle & (w_strobe | (w_expired & ~mem_ack))) r_err <= 1'b1;
      else if (w_clr)                                    r_err <= 1'b0;
    end
  end

  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign MonDReg       = r_mon_d;
  assign monitor_ready = r_ready;
  assign monitor_error = r_err;

endmodule
